sb_recombiner: RTL

- Receive-side counterpart of the DEM-DAC tree switching block. Takes one switching node's registered branch outputs, switching sequence and PN bit, and reconstructs the node input code.
- Checks branch consistency and the odd/even parity rule, and integrates the signed switching sequence to monitor mismatch-shaping balance.
- Sits in the verification/monitor path beside each tree node. Also serves as the building block for a full-tree decoder.

---
 rtl/dem_pkg.sv | 35 +++
 rtl/sb_recombiner_sat_counter.sv | 27 ++
 rtl/sb_recombiner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dem_pkg.sv
// Shared types and saturating arithmetic for the DEM-DAC tree decoders.
// The helpers work on 32-bit values; callers pass the live width and slice the result.
package dem_pkg;

    localparam int DEM_WIDTH     = 5;
    localparam int DEM_ACC_WIDTH = 12;

    typedef logic [DEM_WIDTH-1:0]            code_t;
    typedef logic signed [DEM_ACC_WIDTH-1:0] acc_t;

    // Signed add clamped to the range of a w-bit two's complement number
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = $signed({a[31], a}) + $signed({b[31], b});
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi)
            sum = hi;
        else if (sum < lo)
            sum = lo;
        return sum[31:0];
    endfunction

    // Unsigned increment that holds at the w-bit all-ones value
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input int w);
        logic [32:0] max;
        max = (33'd1 << w) - 33'd1;
        return ({1'b0, c} >= max) ? c : c + 32'd1;
    endfunction

endpackage

// File: rtl/sb_recombiner_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
    import dem_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [31:0] cnt_nxt;
    logic        unused_hi;

    assign cnt_nxt   = sat_inc({{(32-W){1'b0}}, cnt_o}, W);
    assign unused_hi = ^cnt_nxt[31:W];

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i)
            cnt_o <= '0;
        else if (inc_i)
            cnt_o <= cnt_nxt[W-1:0];
    end

endmodule

// File: rtl/sb_recombiner.sv
// Reconstructs a DEM tree node input from its branch outputs, checks the branch
// pair and parity, and integrates the switching sequence to watch shaping balance.
module sb_recombiner
    import dem_pkg::*;
#(
    parameter int WIDTH     = DEM_WIDTH,
    parameter int ACC_WIDTH = DEM_ACC_WIDTH,
    parameter int LIMIT     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     x_out1_i,
    input  logic [WIDTH-1:0]     x_out2_i,
    input  logic [WIDTH-1:0]     s_in_i,
    input  logic                 pn_seq_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     x_rec_o,
    output logic                 cons_err_o,
    output logic                 parity_err_o,
    output logic [ACC_WIDTH-1:0] balance_o,
    output logic                 imbalance_o,
    output logic [CNT_WIDTH-1:0] cons_cnt_o,
    output logic [CNT_WIDTH-1:0] par_cnt_o
);

    typedef struct packed {
        logic [WIDTH-1:0] x_rec;
        logic             cons_err;
        logic             parity_err;
        logic [WIDTH-1:0] s;
        logic             pn;
    } s1_t;

    logic [1:0]                  vld_pipe;
    s1_t                         s1_d, s1_q;
    logic [WIDTH-1:0]            s_x2;
    logic [WIDTH-1:0]            x2_exp;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [31:0]          acc_step;
    logic signed [31:0]          acc_sum;
    logic                        acc_upd;
    logic                        acc_over;
    logic                        unused_acc;

    // Stage 1: undo the node split; all sums wrap at WIDTH bits by construction
    assign s_x2 = {s_in_i[WIDTH-2:0], 1'b0};

    always_comb begin
        s1_d = '0;
        if (pn_seq_i) begin
            s1_d.x_rec = x_out1_i - s_in_i;
            x2_exp     = x_out1_i - s_x2;
        end else begin
            s1_d.x_rec = x_out1_i + s_in_i;
            x2_exp     = x_out1_i + s_x2;
        end
        s1_d.cons_err   = (x_out2_i != x2_exp);
        s1_d.parity_err = (s_in_i[0] != s1_d.x_rec[0]);
        s1_d.s          = s_in_i;
        s1_d.pn         = pn_seq_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_pipe <= '0;
            s1_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], valid_i};
            if (valid_i)
                s1_q <= s1_d;
        end
    end

    // Stage 2: outputs hold between samples
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_rec_o      <= '0;
            cons_err_o   <= 1'b0;
            parity_err_o <= 1'b0;
        end else if (vld_pipe[0]) begin
            x_rec_o      <= s1_q.x_rec;
            cons_err_o   <= s1_q.cons_err;
            parity_err_o <= s1_q.parity_err;
        end
    end

    assign valid_o = vld_pipe[1];

    // Balance integrator: a sample meeting clear_i is dropped, not accumulated
    assign acc_step = s1_q.pn ?  $signed({{(32-WIDTH){1'b0}}, s1_q.s})
                              : -$signed({{(32-WIDTH){1'b0}}, s1_q.s});
    assign acc_sum  = sat_add({{(32-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}, acc_step, ACC_WIDTH);
    assign acc_upd  = vld_pipe[0] & ~clear_i;
    assign acc_over = (acc_sum > LIMIT) || (acc_sum < -LIMIT);
    assign unused_acc = ^acc_sum[31:ACC_WIDTH];

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            acc_q       <= '0;
            imbalance_o <= 1'b0;
        end else if (acc_upd) begin
            acc_q <= acc_sum[ACC_WIDTH-1:0];
            if (acc_over)
                imbalance_o <= 1'b1;
        end
    end

    assign balance_o = acc_q;

    sat_counter #(.W(CNT_WIDTH)) u_cons_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (vld_pipe[0] & s1_q.cons_err),
        .cnt_o   (cons_cnt_o)
    );

    sat_counter #(.W(CNT_WIDTH)) u_par_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (vld_pipe[0] & s1_q.parity_err),
        .cnt_o   (par_cnt_o)
    );

endmodule
